// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite motion controller.
//   state_e  : update sequencer states
//   coord_t  : 10-bit screen coordinate
//   X_MAX/Y_MAX : largest legal sprite left/top edge for the default
//                 640x480 active area with a 64x64 sprite
package sprite_pkg;

    typedef enum logic [1:0] {
        WAIT_TICK = 2'd0,
        UPD_X     = 2'd1,
        UPD_Y     = 2'd2,
        DONE      = 2'd3
    } state_e;

    typedef logic [9:0] coord_t;

    localparam coord_t X_MAX = 10'd576;
    localparam coord_t Y_MAX = 10'd416;

endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// Combinational single-axis step with reflection at 0 and MAX.
//   pos/dir/speed   : current position, direction (1 = increasing), step size
//   pos_nxt/dir_nxt : position and direction after one step
//   reflect         : the step hit (or landed exactly on) an edge
// Arithmetic is carried in 11 bits so pos + speed can never wrap.
module axis_step
    import sprite_pkg::*;
#(
    parameter int MAX = 576
) (
    input  coord_t     pos,
    input  logic       dir,
    input  logic [3:0] speed,
    output coord_t     pos_nxt,
    output logic       dir_nxt,
    output logic       reflect
);

    logic [10:0] pos_w_s;
    logic [10:0] spd_w_s;
    logic [10:0] sum_s;
    logic [10:0] max_s;
    coord_t      diff_s;

    assign pos_w_s = {1'b0, pos};
    assign spd_w_s = {7'd0, speed};
    assign sum_s   = pos_w_s + spd_w_s;
    assign max_s   = 11'(MAX);
    assign diff_s  = pos - {6'd0, speed};

    // Next position/direction; a zero speed freezes the axis without reflecting
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        reflect = 1'b0;
        if (speed == 4'd0) begin
            pos_nxt = pos;
            dir_nxt = dir;
            reflect = 1'b0;
        end else if (dir) begin
            if (sum_s >= max_s) begin
                pos_nxt = max_s[9:0];
                dir_nxt = 1'b0;
                reflect = 1'b1;
            end else begin
                pos_nxt = sum_s[9:0];
                dir_nxt = dir;
                reflect = 1'b0;
            end
        end else begin
            if (pos_w_s <= spd_w_s) begin
                pos_nxt = 10'd0;
                dir_nxt = 1'b1;
                reflect = 1'b1;
            end else begin
                pos_nxt = diff_s;
                dir_nxt = dir;
                reflect = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: moves one 64x64 sprite and bounces it off the
// active-area edges, updating the position only inside vertical blanking.
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   pixelx, pixely  : sync-generator counters
//   run             : free-running motion (one update per FRAME_DIV frames)
//   step            : while run is low, arms exactly one update
//   speed           : pixels per update on both axes
//   posx, posy      : sprite left/top edge to the renderer
//   dirx, diry      : current direction per axis (1 = increasing)
//   bounce          : one-cycle pulse when an update reflected on any axis
//   upd             : one-cycle pulse when a new posx/posy pair is valid
// The first line of blanking produces one tick per frame; a scheduled tick
// walks WAIT_TICK -> UPD_X -> UPD_Y -> DONE, so upd appears 3 cycles later.
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int SPRITE_W  = 64,
    parameter int INIT_X    = 288,
    parameter int INIT_Y    = 208,
    parameter int FRAME_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pixelx,
    input  logic [9:0] pixely,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] speed,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       dirx,
    output logic       diry,
    output logic       bounce,
    output logic       upd
);

    state_e     state_r;
    state_e     state_nxt_s;
    logic       ly_r;
    logic       tick_s;
    logic       tick_wait_s;
    logic       div_hit_s;
    logic       sched_s;
    logic [7:0] cnt_r;
    logic       step_armed_r;
    logic [3:0] speed_r;
    coord_t     posx_r;
    coord_t     posy_r;
    logic       dirx_r;
    logic       diry_r;
    logic       reflx_r;
    logic       upd_r;
    logic       bounce_r;
    logic       ld_x_s;
    logic       ld_y_s;
    coord_t     posx_nxt_s;
    coord_t     posy_nxt_s;
    logic       dirx_nxt_s;
    logic       diry_nxt_s;
    logic       reflx_s;
    logic       refly_s;
    logic       pixelx_unused_s;

    // The frame tick is derived from the line count alone; the column is not needed.
    assign pixelx_unused_s = ^pixelx;

    assign tick_s      = (pixely == 10'(V_ACTIVE)) & ~ly_r;
    assign tick_wait_s = tick_s & (state_r == WAIT_TICK);
    assign div_hit_s   = (cnt_r == 8'(FRAME_DIV - 1));
    // A step armed in the tick cycle itself is only visible at the next tick.
    assign sched_s     = tick_wait_s & (run ? div_hit_s : step_armed_r);

    axis_step #(.MAX(H_ACTIVE - SPRITE_W)) u_axis_x (
        .pos     (posx_r),
        .dir     (dirx_r),
        .speed   (speed_r),
        .pos_nxt (posx_nxt_s),
        .dir_nxt (dirx_nxt_s),
        .reflect (reflx_s)
    );

    axis_step #(.MAX(V_ACTIVE - SPRITE_W)) u_axis_y (
        .pos     (posy_r),
        .dir     (diry_r),
        .speed   (speed_r),
        .pos_nxt (posy_nxt_s),
        .dir_nxt (diry_nxt_s),
        .reflect (refly_s)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WAIT_TICK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_TICK: begin
                if (sched_s) begin
                    state_nxt_s = UPD_X;
                end else begin
                    state_nxt_s = WAIT_TICK;
                end
            end
            UPD_X:   state_nxt_s = UPD_Y;
            UPD_Y:   state_nxt_s = DONE;
            DONE:    state_nxt_s = WAIT_TICK;
            default: state_nxt_s = WAIT_TICK;
        endcase
    end

    // Sequencer outputs: per-axis load strobes
    always_comb begin
        ld_x_s = 1'b0;
        ld_y_s = 1'b0;
        case (state_r)
            UPD_X: ld_x_s = 1'b1;
            UPD_Y: ld_y_s = 1'b1;
            default: begin
                ld_x_s = 1'b0;
                ld_y_s = 1'b0;
            end
        endcase
    end

    // Line-480 edge detector history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ly_r <= 1'b0;
        end else begin
            ly_r <= (pixely == 10'(V_ACTIVE));
        end
    end

    // Frame divider: advances on ticks only while running, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (tick_wait_s && run) begin
            cnt_r <= div_hit_s ? 8'd0 : cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Single-step arming; a new step wins over consumption in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_armed_r <= 1'b0;
        end else if (step && !run) begin
            step_armed_r <= 1'b1;
        end else if (sched_s && !run) begin
            step_armed_r <= 1'b0;
        end else begin
            step_armed_r <= step_armed_r;
        end
    end

    // Speed snapshot taken on entry to UPD_X and shared by both axes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_r <= 4'd0;
        end else if (sched_s) begin
            speed_r <= speed;
        end else begin
            speed_r <= speed_r;
        end
    end

    // X axis position, direction and reflect flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posx_r  <= 10'(INIT_X);
            dirx_r  <= 1'b1;
            reflx_r <= 1'b0;
        end else if (ld_x_s) begin
            posx_r  <= posx_nxt_s;
            dirx_r  <= dirx_nxt_s;
            reflx_r <= reflx_s;
        end else begin
            posx_r  <= posx_r;
            dirx_r  <= dirx_r;
            reflx_r <= reflx_r;
        end
    end

    // Y axis position and direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posy_r <= 10'(INIT_Y);
            diry_r <= 1'b1;
        end else if (ld_y_s) begin
            posy_r <= posy_nxt_s;
            diry_r <= diry_nxt_s;
        end else begin
            posy_r <= posy_r;
            diry_r <= diry_r;
        end
    end

    // Status pulses, registered so they are high exactly during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_r    <= 1'b0;
            bounce_r <= 1'b0;
        end else begin
            upd_r    <= ld_y_s;
            bounce_r <= ld_y_s & (reflx_r | refly_s);
        end
    end

    assign posx   = posx_r;
    assign posy   = posy_r;
    assign dirx   = dirx_r;
    assign diry   = diry_r;
    assign upd    = upd_r;
    assign bounce = bounce_r;

endmodule
